// File: rtl/pe_datain_sequencer_if.sv
// Row-buffer and PE-array handshake bundle for the datain sequencer.
// Both links transfer on a rising edge where the request/valid and the matching ready/valid are both high; the side that raised its flag holds it and its payload until that edge.
interface pe_datain_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int HOUT       = 28,
  parameter int ROW_WIDTH  = 10
);
  logic [2:0][ROW_WIDTH-1:0]       R_C_Channel;
  logic                            pe_ctrl_ready;
  logic [HOUT-1:0][DATA_WIDTH-1:0] pe_ctrl_data;
  logic                            row_buffer_data_valid;
  logic                            pe_buffer_switch;
  logic [HOUT-1:0][DATA_WIDTH-1:0] pe_data;
  logic                            pe_data_valid;
  logic                            pe_data_ready;

  modport master (
    output R_C_Channel, pe_ctrl_ready, pe_buffer_switch, pe_data, pe_data_valid,
    input  pe_ctrl_data, row_buffer_data_valid, pe_data_ready
  );

  modport slave (
    input  R_C_Channel, pe_ctrl_ready, pe_buffer_switch, pe_data, pe_data_valid,
    output pe_ctrl_data, row_buffer_data_valid, pe_data_ready
  );
endinterface

// File: rtl/pe_datain_sequencer.sv
// Walks (channel, kernel row, kernel col) over one pass, fetching each row-buffer
// word and presenting it to the PE array, then pulses a buffer switch and done.
module pe_datain_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int HOUT       = 28,
  parameter int K          = 3,
  parameter int C          = 256,
  parameter int ROW_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  pe_datain_sequencer_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {IDLE, REQ, OUT, SWITCH} state_t;

  localparam logic [ROW_WIDTH-1:0] K_LAST = ROW_WIDTH'(K - 1);
  localparam logic [ROW_WIDTH-1:0] C_LAST = ROW_WIDTH'(C - 1);
  localparam logic [ROW_WIDTH-1:0] ONE    = ROW_WIDTH'(1);

  state_t                          state, state_nxt;
  logic [ROW_WIDTH-1:0]            row_q, col_q, ch_q;
  logic [HOUT-1:0][DATA_WIDTH-1:0] data_q;
  logic                            last_idx;
  logic                            capture;
  logic                            accept;

  assign last_idx = (row_q == K_LAST) && (col_q == K_LAST) && (ch_q == C_LAST);
  assign capture  = (state == REQ) && bus.row_buffer_data_valid;
  assign accept   = (state == OUT) && bus.pe_data_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = REQ;
      REQ:     if (capture) state_nxt = OUT;
      OUT:     if (accept)  state_nxt = last_idx ? SWITCH : REQ;
      SWITCH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every handshake output decodes the registered state, so reset clears them at once.
  always_comb begin
    bus.pe_ctrl_ready    = 1'b0;
    bus.pe_data_valid    = 1'b0;
    bus.pe_buffer_switch = 1'b0;
    done                 = 1'b0;
    busy                 = (state != IDLE);
    case (state)
      REQ:     bus.pe_ctrl_ready = 1'b1;
      OUT:     bus.pe_data_valid = 1'b1;
      SWITCH: begin
        bus.pe_buffer_switch = 1'b1;
        done                 = 1'b1;
      end
      default: ;
    endcase
  end

  // Column is the fastest index; the final carry wraps everything back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
      ch_q  <= '0;
    end else if ((state == IDLE) && start) begin
      row_q <= '0;
      col_q <= '0;
      ch_q  <= '0;
    end else if (accept) begin
      if (col_q == K_LAST) begin
        col_q <= '0;
        if (row_q == K_LAST) begin
          row_q <= '0;
          ch_q  <= (ch_q == C_LAST) ? '0 : ch_q + ONE;
        end else begin
          row_q <= row_q + ONE;
        end
      end else begin
        col_q <= col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        data_q <= '0;
    else if (capture) data_q <= bus.pe_ctrl_data;
  end

  assign bus.pe_data     = data_q;
  assign bus.R_C_Channel = {ch_q, col_q, row_q};
  assign dbg_state       = state;

endmodule
